enemy_draw_sequencer: RTL and testbench

Schedules the shared VGA write port between the per-enemy sprite drawers during the control FSM's draw state. It grants drawers one at a time in index order and skips dead enemies. While a drawer holds the grant, its pixel stream (colour, x, y, write) is routed to the VGA interface. One draw_done is reported to control after every live enemy has finished or timed out.

---
 rtl/zelda_pkg.sv | 18 +
 rtl/priority_select.sv | 24 ++
 rtl/enemy_draw_sequencer.sv | 136 +++++++++++++
 tb/tb_enemy_draw_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/zelda_pkg.sv
// Shared types and constants for the sprite draw path.
package zelda_pkg;

  localparam int COLOUR_W = 6;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_SELECT = 2'd1,
    SEQ_RUN    = 2'd2,
    SEQ_DONE   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/priority_select.sv
// Combinational finder: lowest set bit of mask at an index >= start.
module priority_select #(
  parameter int N  = 3,
  parameter int IW = $clog2(N + 1)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] index
);

  // Scan from the top down so the lowest qualifying index is the last one written.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(start))) begin
        found = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/enemy_draw_sequencer.sv
// Grants the shared VGA write port to enemy sprite drawers one at a time,
// skipping dead enemies, and reports a single draw_done per draw phase.
module enemy_draw_sequencer #(
  parameter int NUM_ENEMIES = 3,
  parameter int COLOUR_W    = zelda_pkg::COLOUR_W,
  parameter int X_W         = zelda_pkg::X_W,
  parameter int Y_W         = zelda_pkg::Y_W,
  parameter int TIMEOUT     = 1023
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            draw,
  input  logic [NUM_ENEMIES-1:0]          alive,
  input  logic [NUM_ENEMIES-1:0]          enemy_done,
  input  logic [NUM_ENEMIES*COLOUR_W-1:0] enemy_colour,
  input  logic [NUM_ENEMIES*X_W-1:0]      enemy_x,
  input  logic [NUM_ENEMIES*Y_W-1:0]      enemy_y,
  input  logic [NUM_ENEMIES-1:0]          enemy_write,
  output logic [NUM_ENEMIES-1:0]          draw_start,
  output logic [COLOUR_W-1:0]             colour,
  output logic [X_W-1:0]                  x_draw,
  output logic [Y_W-1:0]                  y_draw,
  output logic                            VGA_write,
  output logic                            draw_done,
  output logic                            timeout_err
);
  import zelda_pkg::*;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(NUM_ENEMIES + 1);

  seq_state_e             state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [IW-1:0]          cur_q, cur_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [NUM_ENEMIES-1:0] mask_q, mask_d;
  logic                   err_q, err_d;

  logic                   sel_found;
  logic [IW-1:0]          sel_index;

  priority_select #(.N(NUM_ENEMIES), .IW(IW)) u_sel (
    .mask  (mask_q),
    .start (idx_q),
    .found (sel_found),
    .index (sel_index)
  );

  // State register; reset may land mid-grant and returns everything to idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
      idx_q   <= '0;
      cur_q   <= '0;
      timer_q <= '0;
      mask_q  <= '0;
      err_q   <= OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      timer_q <= timer_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: draw low anywhere aborts to idle, keeping the error flag.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    timer_d = timer_q;
    mask_d  = mask_q;
    err_d   = err_q;
    case (state_q)
      SEQ_IDLE: begin
        if (draw) begin
          mask_d  = alive;
          idx_d   = '0;
          err_d   = OFF;
          state_d = SEQ_SELECT;
        end
      end
      SEQ_SELECT: begin
        if (!draw) begin
          state_d = SEQ_IDLE;
        end else if (sel_found) begin
          cur_d   = sel_index;
          timer_d = '0;
          state_d = SEQ_RUN;
        end else begin
          state_d = SEQ_DONE;
        end
      end
      SEQ_RUN: begin
        if (!draw) begin
          state_d = SEQ_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
          // timer_q==0 is the first grant cycle: a done level left over from
          // the previous frame must not end this grant.
          if ((timer_q != '0) &&
              (enemy_done[cur_q] || (timer_q == TW'(TIMEOUT)))) begin
            idx_d   = cur_q + IW'(1);
            state_d = SEQ_SELECT;
            if (timer_q == TW'(TIMEOUT)) err_d = ON;
          end
        end
      end
      SEQ_DONE: begin
        if (!draw) state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // Output mux: only the granted drawer reaches the VGA port.
  always_comb begin
    draw_start  = '0;
    colour      = '0;
    x_draw      = '0;
    y_draw      = '0;
    VGA_write   = OFF;
    draw_done   = (state_q == SEQ_DONE);
    timeout_err = err_q;
    if (state_q == SEQ_RUN) begin
      draw_start = {{(NUM_ENEMIES-1){1'b0}}, 1'b1} << cur_q;
      colour     = enemy_colour[int'(cur_q)*COLOUR_W +: COLOUR_W];
      x_draw     = enemy_x[int'(cur_q)*X_W +: X_W];
      y_draw     = enemy_y[int'(cur_q)*Y_W +: Y_W];
      VGA_write  = enemy_write[cur_q];
    end
  end

endmodule

// File: tb/tb_enemy_draw_sequencer.sv
// Directed bench for enemy_draw_sequencer (3 enemies, TIMEOUT 1023).
module tb_enemy_draw_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        draw;
  logic [2:0]  alive;
  logic [2:0]  enemy_done;
  logic [17:0] enemy_colour;
  logic [26:0] enemy_x;
  logic [23:0] enemy_y;
  logic [2:0]  enemy_write;
  logic [2:0]  draw_start;
  logic [5:0]  colour;
  logic [8:0]  x_draw;
  logic [7:0]  y_draw;
  logic        VGA_write;
  logic        draw_done;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  enemy_draw_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .draw         (draw),
    .alive        (alive),
    .enemy_done   (enemy_done),
    .enemy_colour (enemy_colour),
    .enemy_x      (enemy_x),
    .enemy_y      (enemy_y),
    .enemy_write  (enemy_write),
    .draw_start   (draw_start),
    .colour       (colour),
    .x_draw       (x_draw),
    .y_draw       (y_draw),
    .VGA_write    (VGA_write),
    .draw_done    (draw_done),
    .timeout_err  (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the first cycle of enemy i's grant; serves it for hold+1 cycles
  // then raises done, and returns in the idle cycle after the grant drops.
  task automatic run_grant(input int i, input int hold);
    chk($sformatf("grant%0d", i), 32'(draw_start), 32'(1 << i));
    enemy_write = 3'b111;
    #1;
    chk($sformatf("vga_wr%0d", i), 32'(VGA_write), 32'd1);
    chk($sformatf("colour%0d", i), 32'(colour), 32'(17 * (i + 1)));
    chk($sformatf("x%0d", i), 32'(x_draw), 32'(256 + i + 1));
    chk($sformatf("y%0d", i), 32'(y_draw), 32'(64 + i + 1));
    enemy_write = ~(3'b001 << i);
    #1;
    chk($sformatf("vga_wr_other%0d", i), 32'(VGA_write), 32'd0);
    enemy_write = 3'b000;
    repeat (hold) tick();
    enemy_done[i] = 1'b1;
    tick();
    chk($sformatf("drop%0d", i), 32'(draw_start), 32'd0);
    enemy_done[i] = 1'b0;
  endtask

  initial begin
    int cnt;
    reset        = 1'b1;
    draw         = 1'b0;
    alive        = 3'b000;
    enemy_done   = 3'b000;
    enemy_write  = 3'b000;
    enemy_colour = {6'h33, 6'h22, 6'h11};
    enemy_x      = {9'h103, 9'h102, 9'h101};
    enemy_y      = {8'h43, 8'h42, 8'h41};
    tick();
    tick();
    chk("rst_start", 32'(draw_start), 32'd0);
    chk("rst_done", 32'(draw_done), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    chk("rst_vga", 32'(VGA_write), 32'd0);
    reset = 1'b0;

    // 1: all three alive, served in index order with an idle cycle between.
    alive = 3'b111;
    draw  = 1'b1;
    tick();
    chk("t1_select", 32'(draw_start), 32'd0);
    tick();
    run_grant(0, 4);
    tick();
    run_grant(1, 4);
    tick();
    run_grant(2, 4);
    chk("t1_done_k1", 32'(draw_done), 32'd0);
    tick();
    chk("t1_done_k2", 32'(draw_done), 32'd1);
    tick();
    chk("t1_done_held", 32'(draw_done), 32'd1);
    draw = 1'b0;
    tick();
    chk("t1_done_drop", 32'(draw_done), 32'd0);

    // 2: enemy 1 dead; alive changes and foreign done after start are ignored.
    alive = 3'b101;
    draw  = 1'b1;
    tick();
    tick();
    alive      = 3'b111;
    enemy_done = 3'b100;
    tick();
    tick();
    chk("t2_foreign_done", 32'(draw_start), 32'd1);
    enemy_done = 3'b000;
    run_grant(0, 2);
    tick();
    run_grant(2, 3);
    tick();
    chk("t2_done", 32'(draw_done), 32'd1);
    draw = 1'b0;
    tick();

    // 3: nothing alive, done two cycles after draw rises.
    alive = 3'b000;
    draw  = 1'b1;
    tick();
    chk("t3_n1_done", 32'(draw_done), 32'd0);
    tick();
    chk("t3_n2_done", 32'(draw_done), 32'd1);
    chk("t3_no_grant", 32'(draw_start), 32'd0);
    draw = 1'b0;
    tick();

    // 4: enemy 1 never finishes and times out after 1024 grant cycles.
    alive = 3'b111;
    draw  = 1'b1;
    tick();
    tick();
    run_grant(0, 2);
    tick();
    cnt = 0;
    while (draw_start == 3'b010 && cnt < 1100) begin
      cnt++;
      tick();
    end
    chk("t4_grant_len", 32'(cnt), 32'd1024);
    chk("t4_err", 32'(timeout_err), 32'd1);
    chk("t4_drop", 32'(draw_start), 32'd0);
    tick();
    run_grant(2, 3);
    tick();
    chk("t4_done", 32'(draw_done), 32'd1);
    chk("t4_err_held", 32'(timeout_err), 32'd1);
    draw = 1'b0;
    tick();
    chk("t4_err_idle", 32'(timeout_err), 32'd1);

    // 5: draw falls while enemy 1 runs; next phase restarts from enemy 0.
    draw = 1'b1;
    tick();
    chk("t5_err_clr", 32'(timeout_err), 32'd0);
    tick();
    run_grant(0, 2);
    tick();
    chk("t5_grant1", 32'(draw_start), 32'd2);
    enemy_write = 3'b010;
    draw        = 1'b0;
    tick();
    chk("t5_abort_start", 32'(draw_start), 32'd0);
    chk("t5_abort_vga", 32'(VGA_write), 32'd0);
    enemy_write = 3'b000;
    draw        = 1'b1;
    tick();
    tick();
    chk("t5_restart", 32'(draw_start), 32'd1);

    // 6: reset mid-grant, then a stale done is held across the next grant.
    enemy_write = 3'b001;
    #1;
    chk("t6_pre_vga", 32'(VGA_write), 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_start", 32'(draw_start), 32'd0);
    chk("t6_rst_vga", 32'(VGA_write), 32'd0);
    chk("t6_rst_pix", {3'b0, colour, x_draw, y_draw}, 32'd0);
    chk("t6_rst_flags", 32'({draw_done, timeout_err}), 32'd0);
    reset       = 1'b0;
    enemy_write = 3'b000;
    enemy_done  = 3'b001;
    tick();
    tick();
    chk("t6_grant", 32'(draw_start), 32'd1);
    tick();
    chk("t6_stale_ignored", 32'(draw_start), 32'd1);
    tick();
    chk("t6_done_taken", 32'(draw_start), 32'd0);
    enemy_done = 3'b000;
    draw       = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
